piece_ctrl: RTL and testbench
=============================

PIECE_CTRL -- requirements
Module: piece_ctrl

Interface
REQ-001 Parameters SHALL be: SIZE, default 16, cell pitch in pixels; FIELD_X0, default 160, playfield left edge in pixels; FIELD_Y0, default 80, playfield top edge in pixels; COLS, default 10, playfield columns; ROWS, default 20, playfield rows; SPAWN_COL, default 4, spawn column; GRAV_TICKS, default 25_000_000, cycles per gravity step (>=2).
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Ports SHALL be (name, direction, width, meaning):
 clk  in  1  clock
 rst_n  in  1  synchronous active-low reset
 start  in  1  spawn-request pulse, accepted only in IDLE or OVER
 spawn_type  in  3  piece type sampled with start
 cmd_valid  in  1  move command valid
 cmd  in  2  0 left, 1 right, 2 rotate, 3 soft drop
 cmd_ready  out  1  high only in READY
 rom_type  out  3  shape-ROM type index
 rom_orient  out  2  shape-ROM orientation index
 rom_mask  in  12  combinational ROM result, same bit map as blockNeighbors
 q_valid  out  1  board collision query valid
 q_x, q_y  out  10 each  candidate ref pixel position
 q_mask  out  12  candidate mask
 q_ready  in  1  board accepts query and returns result the same cycle
 q_hit  in  1  candidate overlaps settled cells; valid when q_valid & q_ready
 ref_x, ref_y  out  10 each  committed ref pixel position of the falling piece
 blockNeighbors  out  12  committed mask
 piece_active  out  1  falling piece displayed
 lock_valid  out  1  piece landed; ref/mask hold final values
 lock_ready  in  1  board has absorbed locked piece
 game_over  out  1  spawn collided

Function
REQ-004 Mask bit k SHALL map to cell offset (dc,dr): 0(-1,0) 1(0,0) 2(1,0) 3(2,0) 4(3,0) 5(-1,1) 6(0,1) 7(1,1) 8(-1,2) 9(0,2) 10(1,2) 11(0,3).
REQ-005 Position SHALL be held as signed column col (range -1..COLS) and unsigned row; ref_x = FIELD_X0 + col*SIZE and ref_y = FIELD_Y0 + row*SIZE, truncated to 10 bits.
REQ-006 The states SHALL be IDLE, READY, CHECK, QUERY, LOCK and OVER.
REQ-007 From IDLE or OVER, start SHALL latch spawn_type and load the candidate (col=SPAWN_COL, row=0, orient=0), then enter CHECK.
REQ-008 In READY, cmd_valid SHALL form the candidate: left col-1; right col+1; rotate orient+1 mod 4; soft drop row+1; this is followed by CHECK.
REQ-009 The gravity counter SHALL count only in READY; on reaching GRAV_TICKS-1 it SHALL reset to 0 and set a gravity-pending flag.
REQ-010 If cmd_valid and gravity-pending coincide, the command SHALL win and the flag SHALL stay set; a pending flag with no cmd_valid SHALL start a row+1 candidate and clear the flag.
REQ-011 rom_orient SHALL equal the candidate orient in CHECK and QUERY, and the committed orient otherwise; rom_type SHALL always be the latched type.
REQ-012 CHECK (1 cycle) SHALL reject the candidate if any set rom_mask bit maps to column <0, column >=COLS or row >=ROWS; otherwise QUERY is entered.
REQ-013 QUERY SHALL hold q_valid high with q_x/q_y/q_mask stable until q_ready; q_hit=0 SHALL commit the candidate (position, orient, blockNeighbors=rom_mask) and then READY is entered.
REQ-014 Rejection (bounds or q_hit=1) SHALL act by cause: spawn leads to OVER with game_over=1 and piece_active=0; a downward move (soft drop or gravity) leads to LOCK; left/right/rotate lead back to READY with no change.
REQ-015 LOCK SHALL hold lock_valid=1 until lock_ready; piece_active SHALL drop to 0 and IDLE is entered on the cycle after the handshake.
REQ-016 cmd_ready SHALL be 0 in all states except READY; commands outside READY are ignored, not queued.
REQ-017 The gravity counter and pending flag SHALL be cleared on each successful spawn commit.

Reset
REQ-018 While rst_n=0 at a clk edge, the block SHALL go to IDLE, with ref_x=ref_y=0, blockNeighbors=0, counter=0, flag=0 and every 1-bit output 0; reset mid-QUERY or mid-LOCK SHALL drop q_valid/lock_valid on the next cycle.

Verification
REQ-019 Spawn: start, spawn_type=1, ROM mask 0x0F0 is not valid for this case; use ROM mask 0x00E (bits1-3) with q_hit=0 -> ref_x=224, ref_y=80, piece_active=1 and cmd_ready=1 after the handshake.
REQ-020 Wall: col=0 with mask bit0 set, cmd=left -> no q_valid, position unchanged, back in READY in 2 cycles.
REQ-021 Gravity: GRAV_TICKS=4 with no commands -> ref_y increases by 16 every gravity step plus query latency; a simultaneous cmd=right executes first and the drop follows.
REQ-022 Landing: q_hit=1 on a down move -> lock_valid held while lock_ready=0 for 3 cycles, then IDLE and piece_active=0.
REQ-023 Game over: spawn with q_hit=1 -> game_over=1; a subsequent start clears it and respawns.
REQ-024 Reset: rst_n=0 during QUERY with q_ready=0 -> all outputs are 0 next cycle and the state is IDLE.

Source files
------------

// File: rtl/piece_ctrl_if.sv
// Bus bundle between the falling-piece controller and its surroundings:
// input/command side, shape-ROM lookup, board collision query, lock handshake.
interface piece_ctrl_if;
  logic        start;
  logic [2:0]  spawn_type;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        cmd_ready;
  logic [2:0]  rom_type;
  logic [1:0]  rom_orient;
  logic [11:0] rom_mask;
  logic        q_valid;
  logic [9:0]  q_x;
  logic [9:0]  q_y;
  logic [11:0] q_mask;
  logic        q_ready;
  logic        q_hit;
  logic [9:0]  ref_x;
  logic [9:0]  ref_y;
  logic [11:0] blockNeighbors;
  logic        piece_active;
  logic        lock_valid;
  logic        lock_ready;
  logic        game_over;

  // master: the piece controller
  modport master (
    input  start, spawn_type, cmd_valid, cmd, rom_mask, q_ready, q_hit, lock_ready,
    output cmd_ready, rom_type, rom_orient, q_valid, q_x, q_y, q_mask,
           ref_x, ref_y, blockNeighbors, piece_active, lock_valid, game_over
  );

  // slave: board / input logic / ROM driving the controller
  modport slave (
    output start, spawn_type, cmd_valid, cmd, rom_mask, q_ready, q_hit, lock_ready,
    input  cmd_ready, rom_type, rom_orient, q_valid, q_x, q_y, q_mask,
           ref_x, ref_y, blockNeighbors, piece_active, lock_valid, game_over
  );
endinterface

// File: rtl/piece_ctrl.sv
// Falling-piece controller: spawns a piece, applies move commands and gravity,
// validates each candidate position against field bounds and the board, and
// hands a landed piece to the board through the lock handshake.
module piece_ctrl #(
  parameter int SIZE       = 16,
  parameter int FIELD_X0   = 160,
  parameter int FIELD_Y0   = 80,
  parameter int COLS       = 10,
  parameter int ROWS       = 20,
  parameter int SPAWN_COL  = 4,
  parameter int GRAV_TICKS = 25_000_000
) (
  input logic          clk,
  input logic          rst_n,
  piece_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, READY, CHECK, QUERY, LOCK, OVER} state_t;
  typedef enum logic [1:0] {C_SPAWN, C_DOWN, C_SIDE} cause_t;

  localparam int              CW        = $clog2(GRAV_TICKS);
  localparam logic [CW-1:0]   GRAV_LAST = CW'(GRAV_TICKS - 1);
  localparam logic signed [11:0] COLS_S = 12'(COLS);
  localparam logic [11:0]     ROWS_U    = 12'(ROWS);

  state_t             state;
  cause_t             cause;
  logic [2:0]         typ;
  logic signed [11:0] col, cand_col;
  logic [9:0]         row, cand_row;
  logic [1:0]         orient, cand_orient;
  logic [CW-1:0]      grav_cnt;
  logic               grav_pend;
  logic               cmd_ready, q_valid, lock_valid, piece_active, game_over;
  logic [9:0]         q_x, q_y, ref_x, ref_y;
  logic [11:0]        q_mask, bn;
  logic               oob, reject;

  // Column offset of mask bit k relative to the reference cell.
  function automatic logic signed [11:0] cell_dc(input int k);
    case (k)
      0, 5, 8:     return -12'sd1;
      2, 7, 10:    return 12'sd1;
      3:           return 12'sd2;
      4:           return 12'sd3;
      default:     return 12'sd0;
    endcase
  endfunction

  // Row offset of mask bit k relative to the reference cell.
  function automatic logic [11:0] cell_dr(input int k);
    if (k <= 4)       return 12'd0;
    else if (k <= 7)  return 12'd1;
    else if (k <= 10) return 12'd2;
    else              return 12'd3;
  endfunction

  function automatic logic [9:0] px(input logic signed [11:0] c);
    logic signed [31:0] t;
    t = 32'(FIELD_X0) + 32'(c) * 32'(SIZE);
    return t[9:0];
  endfunction

  function automatic logic [9:0] py(input logic [9:0] r);
    logic [31:0] t;
    t = 32'(FIELD_Y0) + 32'(r) * 32'(SIZE);
    return t[9:0];
  endfunction

  // Any occupied cell of the candidate outside the field walls or below the floor.
  always_comb begin
    logic signed [11:0] cc;
    logic [11:0]        rr;
    oob = 1'b0;
    cc  = '0;
    rr  = '0;
    for (int k = 0; k < 12; k++) begin
      if (bus.rom_mask[k]) begin
        cc = cand_col + cell_dc(k);
        rr = {2'b00, cand_row} + cell_dr(k);
        if (cc < 12'sd0 || cc >= COLS_S || rr >= ROWS_U) oob = 1'b1;
      end
    end
  end

  // Candidate refused either by the bounds check or by the board.
  assign reject = (state == CHECK && oob) ||
                  (state == QUERY && bus.q_ready && bus.q_hit);

  // Main FSM; all outputs registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cause        <= C_SPAWN;
      typ          <= '0;
      col          <= '0;
      row          <= '0;
      orient       <= '0;
      cand_col     <= '0;
      cand_row     <= '0;
      cand_orient  <= '0;
      grav_cnt     <= '0;
      grav_pend    <= 1'b0;
      cmd_ready    <= 1'b0;
      q_valid      <= 1'b0;
      lock_valid   <= 1'b0;
      piece_active <= 1'b0;
      game_over    <= 1'b0;
      q_x          <= '0;
      q_y          <= '0;
      q_mask       <= '0;
      ref_x        <= '0;
      ref_y        <= '0;
      bn           <= '0;
    end else begin
      case (state)
        IDLE, OVER: if (bus.start) begin
          typ         <= bus.spawn_type;
          cand_col    <= 12'(SPAWN_COL);
          cand_row    <= '0;
          cand_orient <= '0;
          cause       <= C_SPAWN;
          game_over   <= 1'b0;
          state       <= CHECK;
        end
        READY: begin
          cand_col    <= col;
          cand_row    <= row;
          cand_orient <= orient;
          if (bus.cmd_valid) begin
            // command beats a pending gravity step; the flag is kept for later
            cmd_ready <= 1'b0;
            state     <= CHECK;
            cause     <= (bus.cmd == 2'd3) ? C_DOWN : C_SIDE;
            case (bus.cmd)
              2'd0:    cand_col    <= col - 12'sd1;
              2'd1:    cand_col    <= col + 12'sd1;
              2'd2:    cand_orient <= orient + 2'd1;
              default: cand_row    <= row + 10'd1;
            endcase
          end else if (grav_pend) begin
            cmd_ready <= 1'b0;
            state     <= CHECK;
            cause     <= C_DOWN;
            cand_row  <= row + 10'd1;
            grav_pend <= 1'b0;
          end
        end
        CHECK: if (!oob) begin
          q_valid <= 1'b1;
          q_x     <= px(cand_col);
          q_y     <= py(cand_row);
          q_mask  <= bus.rom_mask;
          state   <= QUERY;
        end
        QUERY: if (bus.q_ready) begin
          q_valid <= 1'b0;
          if (!bus.q_hit) begin
            col          <= cand_col;
            row          <= cand_row;
            orient       <= cand_orient;
            bn           <= q_mask;
            ref_x        <= q_x;
            ref_y        <= q_y;
            piece_active <= 1'b1;
            cmd_ready    <= 1'b1;
            state        <= READY;
            if (cause == C_SPAWN) begin
              grav_cnt  <= '0;
              grav_pend <= 1'b0;
            end
          end
        end
        LOCK: if (bus.lock_ready) begin
          lock_valid   <= 1'b0;
          piece_active <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // rejected candidate: outcome depends on what produced it
      if (reject) begin
        case (cause)
          C_SPAWN: begin
            state        <= OVER;
            game_over    <= 1'b1;
            piece_active <= 1'b0;
          end
          C_DOWN: begin
            state      <= LOCK;
            lock_valid <= 1'b1;
          end
          default: begin
            state     <= READY;
            cmd_ready <= 1'b1;
          end
        endcase
      end

      // gravity timebase runs only while the piece is waiting for input;
      // placed last so a wrap is never lost against a flag clear
      if (state == READY) begin
        if (grav_cnt == GRAV_LAST) begin
          grav_cnt  <= '0;
          grav_pend <= 1'b1;
        end else begin
          grav_cnt <= grav_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.cmd_ready      = cmd_ready;
  assign bus.rom_type       = typ;
  assign bus.rom_orient     = (state == CHECK || state == QUERY) ? cand_orient : orient;
  assign bus.q_valid        = q_valid;
  assign bus.q_x            = q_x;
  assign bus.q_y            = q_y;
  assign bus.q_mask         = q_mask;
  assign bus.ref_x          = ref_x;
  assign bus.ref_y          = ref_y;
  assign bus.blockNeighbors = bn;
  assign bus.piece_active   = piece_active;
  assign bus.lock_valid     = lock_valid;
  assign bus.game_over      = game_over;

endmodule

// File: tb/tb_piece_ctrl.sv
// Bench for piece_ctrl: a vector table of spawn/move operations with expected
// committed state, checked through a scoreboard queue, plus hand sequences for
// the lock handshake, reset during a query, and gravity timing.
module tb_piece_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic g_rst_n = 1'b0;
  always #5 clk = ~clk;

  piece_ctrl_if bus ();
  piece_ctrl_if gbus ();

  piece_ctrl #(.GRAV_TICKS(100_000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  piece_ctrl #(.GRAV_TICKS(4), .ROWS(4)) gdut (
    .clk(clk), .rst_n(g_rst_n), .bus(gbus.master)
  );

  // shape ROM: type 1 is a 3-wide bar (vertical on odd orients),
  // type 2 is a 2-wide piece using the left-of-ref cell, others a single cell
  function automatic logic [11:0] rom(input logic [2:0] t, input logic [1:0] o);
    case (t)
      3'd1:    return o[0] ? 12'h242 : 12'h00E;
      3'd2:    return 12'h003;
      default: return 12'h002;
    endcase
  endfunction

  assign bus.rom_mask  = rom(bus.rom_type, bus.rom_orient);
  assign gbus.rom_mask = rom(gbus.rom_type, gbus.rom_orient);

  typedef struct {
    logic [2:0]  op;    // 0-3 command, 4 spawn, 5 lock release
    logic [2:0]  typ;
    logic        hit;
    logic [9:0]  ex;
    logic [9:0]  ey;
    logic [11:0] ebn;
    logic        eq;
    logic        elock;
    logic        ego;
    logic        eact;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  vec_t sb_q[$];

  function automatic vec_t mk(input int op, input int typ, input int hit, input int ex,
                              input int ey, input int ebn, input int eq, input int elock,
                              input int ego, input int eact);
    vec_t v;
    v.op = 3'(op); v.typ = 3'(typ); v.hit = hit[0];
    v.ex = 10'(ex); v.ey = 10'(ey); v.ebn = 12'(ebn);
    v.eq = eq[0]; v.elock = elock[0]; v.ego = ego[0]; v.eact = eact[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one spawn/command, follow it to completion, compare against the scoreboard.
  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    int n;
    logic saw_q, done;
    sb_q.push_back(v);
    bus.q_hit = v.hit;
    if (v.op == 3'd4) begin
      bus.spawn_type = v.typ;
      bus.start = 1'b1;
    end else begin
      bus.cmd = v.op[1:0];
      bus.cmd_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.cmd_valid = 1'b0;
    n = 0; saw_q = 1'b0; done = 1'b0;
    while (!done && n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (bus.q_valid) saw_q = 1'b1;
      done = bus.cmd_ready | bus.lock_valid | bus.game_over;
    end
    e = sb_q.pop_front();
    $display("vec %0d op %0d", idx, e.op);
    check("done",   32'(done), 32'd1);
    check("cycles", 32'(n), e.eq ? 32'd2 : 32'd1);
    check("ref_x",  32'(bus.ref_x), 32'(e.ex));
    check("ref_y",  32'(bus.ref_y), 32'(e.ey));
    check("mask",   32'(bus.blockNeighbors), 32'(e.ebn));
    check("query",  32'(saw_q), 32'(e.eq));
    check("lock",   32'(bus.lock_valid), 32'(e.elock));
    check("over",   32'(bus.game_over), 32'(e.ego));
    check("active", 32'(bus.piece_active), 32'(e.eact));
  endtask

  // Board holds off the lock for three cycles, then accepts it.
  task automatic lock_release();
    int held = 0;
    bus.lock_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      if (bus.lock_valid && bus.piece_active) held++;
    end
    check("lock_held", 32'(held), 32'd3);
    bus.lock_ready = 1'b1;
    @(posedge clk); #1;
    bus.lock_ready = 1'b0;
    @(negedge clk);
    check("lock_drop",   32'(bus.lock_valid), 32'd0);
    check("lock_active", 32'(bus.piece_active), 32'd0);
    check("lock_rdy",    32'(bus.cmd_ready), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, 32'({bus.q_valid, bus.cmd_ready, bus.lock_valid,
                               bus.piece_active, bus.game_over}), 32'd0);
    check({tag, "_ref_x"}, 32'(bus.ref_x), 32'd0);
    check({tag, "_ref_y"}, 32'(bus.ref_y), 32'd0);
    check({tag, "_mask"},  32'(bus.blockNeighbors), 32'd0);
  endtask

  // Count cycles until the gravity DUT's ref_y moves away from prev.
  task automatic wait_gy(input logic [9:0] prev, output int n);
    n = 0;
    while (gbus.ref_y == prev && n < 30) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
  endtask

  vec_t vecs[23];

  initial begin
    int n;
    vec_t sv;

    vecs[0]  = mk(4, 1, 0, 224, 80, 'h00E, 1, 0, 0, 1);
    vecs[1]  = mk(1, 0, 0, 240, 80, 'h00E, 1, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 224, 80, 'h00E, 1, 0, 0, 1);
    vecs[3]  = mk(0, 0, 1, 224, 80, 'h00E, 1, 0, 0, 1);
    vecs[4]  = mk(2, 0, 0, 224, 80, 'h242, 1, 0, 0, 1);
    vecs[5]  = mk(3, 0, 0, 224, 96, 'h242, 1, 0, 0, 1);
    vecs[6]  = mk(0, 0, 0, 208, 96, 'h242, 1, 0, 0, 1);
    vecs[7]  = mk(0, 0, 0, 192, 96, 'h242, 1, 0, 0, 1);
    vecs[8]  = mk(0, 0, 0, 176, 96, 'h242, 1, 0, 0, 1);
    vecs[9]  = mk(0, 0, 0, 160, 96, 'h242, 1, 0, 0, 1);
    vecs[10] = mk(0, 0, 0, 160, 96, 'h242, 0, 0, 0, 1);
    vecs[11] = mk(2, 0, 0, 160, 96, 'h00E, 1, 0, 0, 1);
    vecs[12] = mk(3, 0, 1, 160, 96, 'h00E, 1, 1, 0, 1);
    vecs[13] = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(4, 2, 0, 224, 80, 'h003, 1, 0, 0, 1);
    vecs[15] = mk(0, 0, 0, 208, 80, 'h003, 1, 0, 0, 1);
    vecs[16] = mk(0, 0, 0, 192, 80, 'h003, 1, 0, 0, 1);
    vecs[17] = mk(0, 0, 0, 176, 80, 'h003, 1, 0, 0, 1);
    vecs[18] = mk(0, 0, 0, 176, 80, 'h003, 0, 0, 0, 1);
    vecs[19] = mk(3, 0, 1, 176, 80, 'h003, 1, 1, 0, 1);
    vecs[20] = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[21] = mk(4, 1, 1, 176, 80, 'h003, 1, 0, 1, 0);
    vecs[22] = mk(4, 1, 0, 224, 80, 'h00E, 1, 0, 0, 1);

    bus.start = 0; bus.spawn_type = 0; bus.cmd_valid = 0; bus.cmd = 0;
    bus.q_ready = 1; bus.q_hit = 0; bus.lock_ready = 0;
    gbus.start = 0; gbus.spawn_type = 0; gbus.cmd_valid = 0; gbus.cmd = 0;
    gbus.q_ready = 1; gbus.q_hit = 0; gbus.lock_ready = 0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].op == 3'd5) lock_release();
      else run_vec(vecs[i], i);
    end

    // reset while the board stalls a query
    bus.q_ready = 1'b0;
    bus.cmd = 2'd3;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.q_valid && n < 10) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check("qry_valid", 32'(bus.q_valid), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("qry_hold", 32'({bus.q_valid, bus.q_x, bus.q_y, bus.q_mask}),
          32'({1'b1, 10'd224, 10'd96, 12'h00E}));
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midq");
    rst_n = 1'b1;
    bus.q_ready = 1'b1;
    sv = mk(4, 1, 0, 224, 80, 'h00E, 1, 0, 0, 1);
    run_vec(sv, 99);

    // gravity instance: GRAV_TICKS=4, ROWS=4
    repeat (2) @(posedge clk);
    g_rst_n = 1'b1;
    @(negedge clk);
    gbus.spawn_type = 3'd1;
    gbus.start = 1'b1;
    @(posedge clk); #1;
    gbus.start = 1'b0;
    n = 0;
    while (!gbus.cmd_ready && n < 10) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check("g_spawn_y", 32'(gbus.ref_y), 32'd80);
    wait_gy(10'd80, n);
    check("g_step1_y", 32'(gbus.ref_y), 32'd96);
    check("g_step1_t", 32'(n), 32'd7);
    wait_gy(10'd96, n);
    check("g_step2_y", 32'(gbus.ref_y), 32'd112);
    check("g_step2_t", 32'(n), 32'd6);
    // right command lands on the cycle the gravity flag is raised
    repeat (3) @(posedge clk);
    @(negedge clk);
    gbus.cmd = 2'd1;
    gbus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    gbus.cmd_valid = 1'b0;
    n = 0;
    while (gbus.ref_x == 10'd224 && n < 10) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check("g_right_x", 32'(gbus.ref_x), 32'd240);
    check("g_right_y", 32'(gbus.ref_y), 32'd112);
    check("g_right_t", 32'(n), 32'd2);
    wait_gy(10'd112, n);
    check("g_follow_y", 32'(gbus.ref_y), 32'd128);
    check("g_follow_t", 32'(n), 32'd3);
    n = 0;
    while (!gbus.lock_valid && n < 20) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check("g_floor_lock", 32'({gbus.lock_valid, gbus.ref_y}), 32'({1'b1, 10'd128}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
